// File: rtl/result_checker.sv
// rtl/result_checker.sv - breakpoint-triggered RAM result checker with pass/fail counters
// Reads RESULT_BYTES words from RAM on a PC match and compares them to a golden value stream.
module result_checker #(
   parameter int                DATA_W       = 8,
   parameter int                ADDR_W       = 8,
   parameter int                RESULT_BYTES = 2,
   parameter logic [ADDR_W-1:0] RESULT_BASE  = 8'h02,
   parameter logic [ADDR_W-1:0] BREAK_ADDR   = 8'h87,
   parameter int                CNT_W        = 32
) (
   input  logic                           clk,
   input  logic                           arst,
   input  logic                           enable,
   input  logic [ADDR_W-1:0]              pc,
   output logic [ADDR_W-1:0]              mem_addr,
   input  logic [DATA_W-1:0]              mem_rd_data,
   input  logic [RESULT_BYTES*DATA_W-1:0] exp_data,
   input  logic                           exp_valid,
   output logic                           exp_ready,
   output logic                           busy,
   output logic                           chk_done,
   output logic                           chk_pass,
   output logic [RESULT_BYTES*DATA_W-1:0] last_result,
   output logic [CNT_W-1:0]               pass_cnt,
   output logic [CNT_W-1:0]               fail_cnt,
   output logic                           any_fail
);

   localparam int         RW     = RESULT_BYTES * DATA_W;
   localparam logic [3:0] LAST_K = 4'(RESULT_BYTES - 1);

   typedef enum logic [1:0] {IDLE, READ, COMPARE, REARM} state_t;

   state_t         state;
   state_t         state_nx;
   logic [3:0]     k;
   logic [RW-1:0]  cap;
   logic           xfer;
   logic           match;

   always_ff @(posedge clk) begin
      if (arst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      exp_ready = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:    if (enable && pc == BREAK_ADDR) state_nx = READ;
         READ:    if (k == LAST_K) state_nx = COMPARE;
         COMPARE: begin
            exp_ready = 1'b1;
            if (exp_valid) state_nx = REARM;
         end
         // Hold off re-arming until the PC leaves the breakpoint: one check per visit.
         REARM:   if (pc != BREAK_ADDR) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign xfer     = (state == COMPARE) && exp_valid;
   assign match    = (cap == exp_data);
   assign mem_addr = (state == READ) ? RESULT_BASE + ADDR_W'(k) : RESULT_BASE;

   always_ff @(posedge clk) begin
      if (arst) begin
         k           <= '0;
         cap         <= '0;
         chk_done    <= 1'b0;
         chk_pass    <= 1'b0;
         last_result <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         any_fail    <= 1'b0;
      end else begin
         chk_done <= xfer;
         if (state == READ) begin
            for (int i = 0; i < RESULT_BYTES; i++)
               if (k == 4'(i)) cap[i*DATA_W +: DATA_W] <= mem_rd_data;
            k <= (k == LAST_K) ? 4'd0 : k + 4'd1;
         end else begin
            k <= '0;
         end
         if (xfer) begin
            last_result <= cap;
            chk_pass    <= match;
            // Counters saturate so a very long regression never reports a wrapped count.
            if (match) begin
               if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
            end else begin
               if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
               any_fail <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - directed self-checking bench for result_checker
// Default instance plus a narrow-counter instance whose result straddles the RAM address wrap.
module tb_result_checker;

   logic        clk = 1'b0;
   logic        arst, enable;
   logic [7:0]  pc;
   logic [15:0] exp_data, s_exp_data;
   logic        exp_valid;
   logic [7:0]  ram [0:255];

   logic [7:0]  mem_addr, mem_rd_data;
   logic        exp_ready, busy, chk_done, chk_pass, any_fail;
   logic [15:0] last_result;
   logic [31:0] pass_cnt, fail_cnt;

   logic [7:0]  s_mem_addr, s_mem_rd_data;
   logic        s_exp_ready, s_busy, s_chk_done, s_chk_pass, s_any_fail;
   logic [15:0] s_last_result;
   logic [1:0]  s_pass_cnt, s_fail_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mem_rd_data   = ram[mem_addr];
   assign s_mem_rd_data = ram[s_mem_addr];

   result_checker dut (
      .clk(clk), .arst(arst), .enable(enable), .pc(pc),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .exp_data(exp_data), .exp_valid(exp_valid), .exp_ready(exp_ready),
      .busy(busy), .chk_done(chk_done), .chk_pass(chk_pass),
      .last_result(last_result), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .any_fail(any_fail)
   );

   result_checker #(.CNT_W(2), .RESULT_BASE(8'hFF)) dut_s (
      .clk(clk), .arst(arst), .enable(enable), .pc(pc),
      .mem_addr(s_mem_addr), .mem_rd_data(s_mem_rd_data),
      .exp_data(s_exp_data), .exp_valid(exp_valid), .exp_ready(s_exp_ready),
      .busy(s_busy), .chk_done(s_chk_done), .chk_pass(s_chk_pass),
      .last_result(s_last_result), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
      .any_fail(s_any_fail)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      arst = 1'b1; enable = 1'b1; pc = 8'h00; exp_valid = 1'b1;
      step();
      arst = 1'b0;
   endtask

   // One breakpoint visit, then count chk_done pulses over a window long enough to return to IDLE.
   task automatic fire(input logic [15:0] ed, output int pulses);
      exp_data = ed; pc = 8'h87;
      step();
      pc = 8'h00; pulses = 0;
      repeat (12) begin
         step();
         if (chk_done) pulses++;
      end
   endtask

   task automatic test_reset;
      arst = 1'b1; enable = 1'b0; pc = 8'h00; exp_valid = 1'b0; exp_data = '0; s_exp_data = '0;
      step(); step();
      arst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL reset_exp_ready got %0b want 0", exp_ready); end
      checks++; if (mem_addr !== 8'h02) begin errors++; $display("FAIL reset_mem_addr got %h want 02", mem_addr); end
      checks++; if ({chk_done, chk_pass, any_fail} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {chk_done, chk_pass, any_fail}); end
      checks++; if (last_result !== 16'h0000) begin errors++; $display("FAIL reset_last_result got %h want 0000", last_result); end
      checks++; if (pass_cnt !== 32'd0 || fail_cnt !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
      checks++; if (s_mem_addr !== 8'hFF) begin errors++; $display("FAIL reset_s_mem_addr got %h want ff", s_mem_addr); end
   endtask

   task automatic test_basic;
      do_reset();
      exp_data = 16'h1234; pc = 8'h87;
      step();
      pc = 8'h00;
      checks++; if (mem_addr !== 8'h02) begin errors++; $display("FAIL basic_addr0 got %h want 02", mem_addr); end
      step();
      checks++; if (mem_addr !== 8'h03) begin errors++; $display("FAIL basic_addr1 got %h want 03", mem_addr); end
      step();
      checks++; if (exp_ready !== 1'b1 || mem_addr !== 8'h02) begin errors++; $display("FAIL basic_compare got ready=%0b addr=%h want 1/02", exp_ready, mem_addr); end
      step();
      checks++; if (chk_done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b want 1", chk_done); end
      checks++; if (last_result !== 16'h1234 || chk_pass !== 1'b1) begin errors++; $display("FAIL basic_result got %h pass=%0b want 1234/1", last_result, chk_pass); end
      checks++; if (pass_cnt !== 32'd1 || fail_cnt !== 32'd0) begin errors++; $display("FAIL basic_counts got %0d/%0d want 1/0", pass_cnt, fail_cnt); end
      step();
      checks++; if (chk_done !== 1'b0 || exp_ready !== 1'b0) begin errors++; $display("FAIL basic_pulse got done=%0b ready=%0b want 0/0", chk_done, exp_ready); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%0b want 0", busy); end
   endtask

   task automatic test_mismatch;
      int p;
      do_reset();
      fire(16'h1235, p);
      checks++; if (p != 1) begin errors++; $display("FAIL mismatch_pulses got %0d want 1", p); end
      checks++; if (chk_pass !== 1'b0 || fail_cnt !== 32'd1 || any_fail !== 1'b1) begin errors++; $display("FAIL mismatch_state got pass=%0b fail=%0d any=%0b want 0/1/1", chk_pass, fail_cnt, any_fail); end
      fire(16'h1234, p);
      checks++; if (any_fail !== 1'b1 || pass_cnt !== 32'd1 || chk_pass !== 1'b1) begin errors++; $display("FAIL mismatch_sticky got any=%0b pass_cnt=%0d pass=%0b want 1/1/1", any_fail, pass_cnt, chk_pass); end
   endtask

   task automatic test_dwell;
      int p;
      do_reset();
      exp_data = 16'h1234; pc = 8'h87; p = 0;
      repeat (20) begin step(); if (chk_done) p++; end
      checks++; if (p != 1) begin errors++; $display("FAIL dwell_one got %0d want 1", p); end
      pc = 8'h88; step();
      pc = 8'h87; step();
      pc = 8'h00; p = 0;
      repeat (10) begin step(); if (chk_done) p++; end
      checks++; if (p != 1 || pass_cnt !== 32'd2) begin errors++; $display("FAIL dwell_second got %0d pass_cnt=%0d want 1/2", p, pass_cnt); end
   endtask

   task automatic test_stall;
      int bad;
      do_reset();
      exp_valid = 1'b0; exp_data = 16'h1234; pc = 8'h87;
      step();
      pc = 8'h00;
      step(); step();
      bad = 0;
      repeat (10) begin
         step();
         if (exp_ready !== 1'b1 || busy !== 1'b1 || chk_done !== 1'b0 || pass_cnt !== 32'd0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_wait got %0d bad cycles want 0", bad); end
      exp_valid = 1'b1;
      step();
      checks++; if (chk_done !== 1'b1 || pass_cnt !== 32'd1) begin errors++; $display("FAIL stall_done got done=%0b pass_cnt=%0d want 1/1", chk_done, pass_cnt); end
   endtask

   task automatic test_abort;
      int p;
      do_reset();
      exp_data = 16'h1234; pc = 8'h87;
      step();
      pc = 8'h00;
      step();
      arst = 1'b1;
      step();
      arst = 1'b0;
      checks++; if (busy !== 1'b0 || mem_addr !== 8'h02 || chk_done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%0b addr=%h done=%0b want 0/02/0", busy, mem_addr, chk_done); end
      p = 0;
      repeat (5) begin step(); if (chk_done) p++; end
      checks++; if (p != 0 || pass_cnt !== 32'd0 || fail_cnt !== 32'd0) begin errors++; $display("FAIL abort_quiet got pulses=%0d %0d/%0d want 0 0/0", p, pass_cnt, fail_cnt); end
      fire(16'h1234, p);
      checks++; if (p != 1 || pass_cnt !== 32'd1) begin errors++; $display("FAIL abort_rerun got pulses=%0d pass_cnt=%0d want 1/1", p, pass_cnt); end
   endtask

   task automatic test_small;
      int p;
      do_reset();
      s_exp_data = 16'h0000; exp_data = 16'h1234; pc = 8'h87;
      step();
      pc = 8'h00;
      checks++; if (s_mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr0 got %h want ff", s_mem_addr); end
      step();
      checks++; if (s_mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr1 got %h want 00", s_mem_addr); end
      step(); step();
      checks++; if (s_chk_done !== 1'b1 || s_last_result !== 16'hABCD || s_fail_cnt !== 2'd1) begin errors++; $display("FAIL wrap_result got done=%0b res=%h fail=%0d want 1/abcd/1", s_chk_done, s_last_result, s_fail_cnt); end
      repeat (4) step();
      fire(16'h1234, p);
      fire(16'h1234, p);
      checks++; if (s_fail_cnt !== 2'b11) begin errors++; $display("FAIL sat_reach got %b want 11", s_fail_cnt); end
      fire(16'h1234, p);
      checks++; if (s_fail_cnt !== 2'b11 || s_any_fail !== 1'b1 || s_pass_cnt !== 2'b00) begin errors++; $display("FAIL sat_hold got fail=%b any=%0b pass=%b want 11/1/00", s_fail_cnt, s_any_fail, s_pass_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[8'h02] = 8'h34; ram[8'h03] = 8'h12;
      ram[8'hFF] = 8'hCD; ram[8'h00] = 8'hAB;
      test_reset();
      test_basic();
      test_mismatch();
      test_dwell();
      test_stall();
      test_abort();
      test_small();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
Synthesisable self-check block for the 8-bit micro platform. It watches the program counter for a breakpoint address, reads a multi-byte result out of data RAM through a dedicated read port, and compares it with a golden value delivered on a valid/ready stream. Pass and fail counts are kept in hardware, so long regressions and on-board tests need no simulator-side hierarchical peeking.

Parameters:
DATA_W, 8, RAM word width.
ADDR_W, 8, ROM and RAM address width.
RESULT_BYTES, 2, number of RAM words forming one result (1..8).
RESULT_BASE, 8'h02, RAM address of the result's least significant word.
BREAK_ADDR, 8'h87, PC value that triggers a check.
CNT_W, 32, width of the pass and fail counters.

Ports:
clk  in  1  system clock, rising edge.
arst  in  1  reset, synchronous, active-high.
enable  in  1  arms the checker; sampled only in IDLE.
pc  in  ADDR_W  micro rom_addr being watched.
mem_addr  out  ADDR_W  checker RAM read address.
mem_rd_data  in  DATA_W  RAM read data; combinational read of mem_addr.
exp_data  in  RESULT_BYTES*DATA_W  golden result.
exp_valid  in  1  exp_data valid.
exp_ready  out  1  checker accepts exp_data.
busy  out  1  high in every state except IDLE.
chk_done  out  1  one-cycle pulse when a comparison completes.
chk_pass  out  1  result of the last comparison; valid from chk_done onward.
last_result  out  RESULT_BYTES*DATA_W  last captured DUV result.
pass_cnt  out  CNT_W  number of matching checks.
fail_cnt  out  CNT_W  number of mismatching checks.
any_fail  out  1  sticky flag; set on the first mismatch.

Behaviour:
- Reset (arst=1 at a clk edge) forces the following:
  - state = IDLE, mem_addr = RESULT_BASE, exp_ready = 0, busy = 0.
  - chk_done = 0, chk_pass = 0, last_result = 0.
  - pass_cnt = 0, fail_cnt = 0, any_fail = 0, byte index k = 0.
- Reset mid-check abandons the check. No counter update occurs and no chk_done pulse is issued.
- IDLE: if enable=1 and pc==BREAK_ADDR at the edge, go to READ with k=0. Otherwise stay in IDLE.
- READ, one cycle per byte:
  - mem_addr = RESULT_BASE + k, modulo 2^ADDR_W.
  - At each edge, mem_rd_data is stored into byte k of the capture register (LSB first).
  - k increments each cycle; after byte RESULT_BYTES-1, go to COMPARE.
  - The full result is {byte[N-1], ..., byte[0]}.
- COMPARE:
  - exp_ready = 1; wait indefinitely for exp_valid.
  - The transfer happens at the edge where exp_valid & exp_ready are both 1. At that edge:
    - last_result is loaded with the captured value.
    - chk_pass is set to (captured == exp_data).
    - pass_cnt or fail_cnt increments by 1, saturating at all-ones (no wrap).
    - any_fail is set on a mismatch.
  - chk_done is high in the cycle after the transfer. Then go to REARM.
  - exp_ready is 0 in every state other than COMPARE.
- REARM: wait until pc != BREAK_ADDR, then go to IDLE. This guarantees exactly one check per breakpoint visit, even if the PC dwells on BREAK_ADDR.
- pc changing during READ or COMPARE does not abort the check.
- enable=0 mid-check: the current check completes and the checker does not re-arm.
- Outside READ, mem_addr holds RESULT_BASE.
- Latency: pc match sampled at edge E. Bytes are captured at E+1 .. E+N. exp_ready is high from E+N. The earliest transfer is at edge E+N+1, and chk_done is high in the cycle after that edge.
- A pc match in the same cycle that REARM exits is not taken. The checker needs one IDLE cycle before it can arm again.
- If exp_valid is already high on entry to COMPARE, the transfer takes zero extra wait cycles.

Test Plan:
- Defaults; RAM[2]=8'h34, RAM[3]=8'h12; pc steps to 8'h87; exp_data=16'h1234 with exp_valid=1 -> mem_addr reads 8'h02 then 8'h03; last_result=16'h1234; chk_pass=1; pass_cnt=1; single chk_done pulse.
- Same stimulus with exp_data=16'h1235 -> chk_pass=0, fail_cnt=1, any_fail=1. A following matching check leaves any_fail=1 and makes pass_cnt=1.
- pc held at 8'h87 for 20 cycles -> exactly one check. pc goes to 8'h88 and back to 8'h87 -> a second check.
- exp_valid withheld for 10 cycles in COMPARE -> exp_ready stays 1, counters unchanged, busy=1. Check completes one cycle after exp_valid rises.
- arst asserted during READ byte 1 -> next cycle state is IDLE, counters 0, no chk_done. Re-running completes normally.
- CNT_W=2, four failing checks -> fail_cnt reaches 2'b11 and stays there. RESULT_BASE=8'hFF with RESULT_BYTES=2 -> reads 8'hFF then 8'h00.
